// File: rtl/lpc_pkg.sv
// Shared types and defaults for the two-channel LPC frame arbiter.
package lpc_pkg;

   localparam int LPC_DATA_W    = 16;
   localparam int LPC_FRAME_LEN = 4;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   // Source channel identifier, also carried on M_TID.
   typedef logic chan_t;

endpackage

// File: rtl/lpc_frame_arbiter_if.sv
// Bus bundle for lpc_frame_arbiter: two sample sources in, one encoder stream out.
// slave = arbiter view, master = environment view.
interface lpc_frame_arbiter_if
   import lpc_pkg::*;
#(
   parameter int DATA_W = LPC_DATA_W
) ();

   logic              S0_TVALID, S0_TREADY, S0_TLAST, S0_TUSER;
   logic [DATA_W-1:0] S0_TDATA;
   logic              S1_TVALID, S1_TREADY, S1_TLAST, S1_TUSER;
   logic [DATA_W-1:0] S1_TDATA;
   logic              M_TVALID, M_TREADY, M_TLAST, M_TUSER;
   logic [DATA_W-1:0] M_TDATA;
   chan_t             M_TID;

   modport slave (
      input  S0_TVALID, S0_TDATA, S0_TLAST, S0_TUSER,
      input  S1_TVALID, S1_TDATA, S1_TLAST, S1_TUSER,
      input  M_TREADY,
      output S0_TREADY, S1_TREADY,
      output M_TVALID, M_TDATA, M_TLAST, M_TUSER, M_TID
   );

   modport master (
      output S0_TVALID, S0_TDATA, S0_TLAST, S0_TUSER,
      output S1_TVALID, S1_TDATA, S1_TLAST, S1_TUSER,
      output M_TREADY,
      input  S0_TREADY, S1_TREADY,
      input  M_TVALID, M_TDATA, M_TLAST, M_TUSER, M_TID
   );

endinterface

// File: rtl/lpc_arb_pick.sv
// Two-request grant decision. Round-robin on rr by default;
// LPC_ARB_FIXED_PRIO_EN makes channel 0 win every tie and ignores rr.
module lpc_arb_pick
   import lpc_pkg::*;
(
   input  logic [1:0] req,
   input  chan_t      rr,
   output chan_t      grant
);

`ifdef LPC_ARB_FIXED_PRIO_EN
   chan_t unused_rr;
   assign unused_rr = rr;
   assign grant     = ~req[0];
`else
   // Tie goes to the pointed channel; a lone request wins outright.
   assign grant = (&req) ? rr : req[1];
`endif

endmodule

// File: rtl/lpc_frame_arbiter.sv
// Frames samples from two sources onto one encoder stream, FRAME_LEN beats per grant.
// Optional macro LPC_ARB_FIXED_PRIO_EN: fixed channel-0 priority instead of round-robin.
module lpc_frame_arbiter
   import lpc_pkg::*;
#(
   parameter int DATA_W    = LPC_DATA_W,
   parameter int FRAME_LEN = LPC_FRAME_LEN
) (
   input  logic               ACLK,
   input  logic               ARESET_N,
   lpc_frame_arbiter_if.slave bus
);

   logic [0:0]        state;
   chan_t             grant, rr, pick_gnt;
   logic [3:0]        cnt;
   logic [1:0]        req;
   logic              out_free, burst_rdy, accept, last_now;
   logic              sel_vld, sel_last, sel_user;
   logic [DATA_W-1:0] sel_data;
   logic              m_vld, m_last, m_user;
   logic [DATA_W-1:0] m_data;
   chan_t             m_tid;

   assign req = {bus.S1_TVALID, bus.S0_TVALID};

   lpc_arb_pick u_pick (
      .req   (req),
      .rr    (rr),
      .grant (pick_gnt)
   );

   // Output register can take a beat when empty or draining this cycle.
   assign out_free      = ~m_vld | bus.M_TREADY;
   assign burst_rdy     = (state == ST_BURST) & out_free;
   assign bus.S0_TREADY = burst_rdy & (grant == 1'b0);
   assign bus.S1_TREADY = burst_rdy & (grant == 1'b1);

   assign sel_vld  = grant ? bus.S1_TVALID : bus.S0_TVALID;
   assign sel_data = grant ? bus.S1_TDATA  : bus.S0_TDATA;
   assign sel_last = grant ? bus.S1_TLAST  : bus.S0_TLAST;
   assign sel_user = grant ? bus.S1_TUSER  : bus.S0_TUSER;

   assign accept   = burst_rdy & sel_vld;
   assign last_now = (cnt == 4'(FRAME_LEN - 1)) | sel_last | sel_user;

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         state <= ST_IDLE;
         grant <= 1'b0;
         cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (|req) begin
                  grant <= pick_gnt;
                  cnt   <= '0;
                  state <= ST_BURST;
               end
            end
            default: begin
               // Grant is held until the frame closes, even across TVALID gaps.
               if (accept) begin
                  cnt <= cnt + 4'd1;
                  if (last_now) state <= ST_IDLE;
               end
            end
         endcase
      end
   end

`ifdef LPC_ARB_FIXED_PRIO_EN
   assign rr = 1'b0;
`else
   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N)             rr <= 1'b0;
      else if (accept & last_now) rr <= ~grant;
   end
`endif

   always_ff @(posedge ACLK or negedge ARESET_N) begin
      if (!ARESET_N) begin
         m_vld  <= 1'b0;
         m_data <= '0;
         m_last <= 1'b0;
         m_user <= 1'b0;
         m_tid  <= 1'b0;
      end else if (accept) begin
         m_vld  <= 1'b1;
         m_data <= sel_data;
         m_last <= last_now;
         m_user <= sel_user;
         m_tid  <= grant;
      end else if (bus.M_TREADY) begin
         m_vld  <= 1'b0;
      end
   end

   assign bus.M_TVALID = m_vld;
   assign bus.M_TDATA  = m_data;
   assign bus.M_TLAST  = m_last;
   assign bus.M_TUSER  = m_user;
   assign bus.M_TID    = m_tid;

endmodule
